// File: rtl/vga_vram_arbiter.sv
// Video RAM arbiter/sequencer for 640x480 scan-out of a 320x240 byte
// framebuffer (2x2 pixel doubling). Display reads own every even active
// column; every other cycle drains one buffered CPU write.
module vga_vram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FB_W       = 320,
  parameter int unsigned FB_H       = 240
) (
  input  logic        CLK25MHz,
  input  logic        reset,
  input  logic [10:0] x_coord,
  input  logic [10:0] y_coord,
  input  logic        cpu_wr_en,
  input  logic [16:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic        cpu_full,
  output logic        cpu_drop,
  output logic        vblank,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pixel_out
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [10:0] ACT_W   = 11'(2 * FB_W);
  localparam logic [10:0] ACT_H   = 11'(2 * FB_H);
  localparam logic [16:0] FB_W17  = 17'(FB_W);
  localparam logic [16:0] FB_SIZE = 17'(FB_W * FB_H);

  logic [16:0]      fifo_addr [FIFO_DEPTH];
  logic [7:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic        pend;
  logic        prev_act;
  logic        act;
  logic        disp;
  logic        push;
  logic        pop;
  logic [16:0] row;
  logic [16:0] col;
  logic [16:0] disp_addr;
  logic [16:0] head_addr;
  logic [7:0]  head_data;
  logic        head_ok;

  // Slot decision and FIFO handshakes from the sampled coordinates
  always_comb begin
    act       = (x_coord < ACT_W) && (y_coord < ACT_H);
    disp      = act && !x_coord[0];
    row       = {6'b0, y_coord[10:1]};
    col       = {6'b0, x_coord[10:1]};
    disp_addr = row * FB_W17 + col;
    cpu_full  = (count == CNT_W'(FIFO_DEPTH));
    push      = cpu_wr_en && !cpu_full;
    pop       = !disp && (count != '0);
    head_addr = fifo_addr[rd_ptr];
    head_data = fifo_data[rd_ptr];
    head_ok   = head_addr < FB_SIZE;
  end

  // FIFO storage; contents need no reset since the pointers gate them
  always_ff @(posedge CLK25MHz) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK25MHz) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // RAM port sequencing: display read or CPU write, registered
  always_ff @(posedge CLK25MHz) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cpu_drop  <= 1'b0;
    end else if (disp) begin
      mem_addr <= disp_addr;
      mem_we   <= 1'b0;
    end else if (pop) begin
      mem_addr  <= head_addr;
      mem_wdata <= head_data;
      mem_we    <= head_ok;
      if (!head_ok) cpu_drop <= 1'b1;
    end else begin
      mem_we <= 1'b0;
    end
  end

  // Pixel capture: latch read data after a display slot, blank after
  // inactive coordinates, otherwise hold (odd-column duplicate)
  always_ff @(posedge CLK25MHz) begin
    if (reset) begin
      pend      <= 1'b0;
      prev_act  <= 1'b0;
      pixel_out <= '0;
      vblank    <= 1'b0;
    end else begin
      pend     <= disp;
      prev_act <= act;
      vblank   <= (y_coord >= ACT_H);
      if (pend)          pixel_out <= mem_rdata;
      else if (!prev_act) pixel_out <= '0;
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: RAM model with read data available from the
// registered address, plus a queue-based reference of slot/FIFO behaviour.
module tb_vga_vram_arbiter;

  logic        CLK25MHz = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] x_coord = '0;
  logic [10:0] y_coord = '0;
  logic        cpu_wr_en = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_full;
  logic        cpu_drop;
  logic        vblank;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [7:0]  pixel_out;

  logic [7:0] ram [0:131071];

  vga_vram_arbiter #(.FIFO_DEPTH(4), .FB_W(320), .FB_H(240)) dut (
    .CLK25MHz (CLK25MHz),
    .reset    (reset),
    .x_coord  (x_coord),
    .y_coord  (y_coord),
    .cpu_wr_en(cpu_wr_en),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_full (cpu_full),
    .cpu_drop (cpu_drop),
    .vblank   (vblank),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .pixel_out(pixel_out)
  );

  always #20 CLK25MHz = ~CLK25MHz;

  assign mem_rdata = ram[mem_addr];
  always @(posedge CLK25MHz) if (mem_we) ram[mem_addr] <= mem_wdata;

  // Reference model state
  int q_addr[$];
  int q_data[$];
  int m_addr, m_wdata, m_pixel, m_paddr;
  bit m_we, m_drop, m_vblank, m_full, m_pd, m_pa;
  int passed = 0;
  int total  = 0;

  // Drive one cycle of inputs, advance the model, then wait past the edge
  task automatic step(input int x, input int y, input bit wr, input int a,
                      input int d, input bit rst);
    bit act, disp, full_before;
    int ea;
    x_coord   = 11'(x);
    y_coord   = 11'(y);
    cpu_wr_en = wr;
    cpu_addr  = 17'(a);
    cpu_data  = 8'(d);
    reset     = rst;
    act  = (x < 640) && (y < 480);
    disp = act && (x % 2 == 0);
    if (rst) begin
      q_addr.delete(); q_data.delete();
      m_addr = 0; m_wdata = 0; m_pixel = 0; m_paddr = 0;
      m_we = 0; m_drop = 0; m_vblank = 0; m_pd = 0; m_pa = 0;
    end else begin
      full_before = (q_addr.size() == 4);
      m_vblank = (y >= 480);
      if (m_pd) m_pixel = int'(ram[m_paddr]);
      else if (!m_pa) m_pixel = 0;
      m_pd = disp;
      m_pa = act;
      m_paddr = (y / 2) * 320 + (x / 2);
      if (disp) begin
        m_addr = m_paddr;
        m_we   = 0;
      end else if (q_addr.size() > 0) begin
        ea      = q_addr.pop_front();
        m_wdata = q_data.pop_front();
        m_addr  = ea;
        m_we    = (ea < 76800);
        if (ea >= 76800) m_drop = 1;
      end else begin
        m_we = 0;
      end
      if (wr && !full_before) begin
        q_addr.push_back(a);
        q_data.push_back(d & 8'hFF);
      end
    end
    m_full = (q_addr.size() == 4);
    @(posedge CLK25MHz);
    #1;
    cpu_wr_en = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    step(700, 490, 0, 0, 0, 1);
    step(700, 490, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 100 + i, i, 0);
    step(700, 490, 0, 0, 0, 1);
    step(700, 490, 0, 0, 0, 1);
    total++; if (cpu_full !== 1'b0) $display("FAIL reset_full: got %0b want 0", cpu_full); else passed++;
    total++; if (pixel_out !== 8'h00) $display("FAIL reset_pixel: got %0h want 0", pixel_out); else passed++;
    total++; if (mem_addr !== 17'd0) $display("FAIL reset_addr: got %0d want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 8'h00) $display("FAIL reset_wdata: got %0h want 0", mem_wdata); else passed++;
    total++; if (cpu_drop !== 1'b0) $display("FAIL reset_drop: got %0b want 0", cpu_drop); else passed++;
    total++; if (vblank !== 1'b0) $display("FAIL reset_vblank: got %0b want 0", vblank); else passed++;
    for (int i = 0; i < 6; i++) begin
      step(700, 490, 0, 0, 0, 0);
      total++; if (mem_we !== 1'b0) $display("FAIL reset_no_we[%0d]: got %0b want 0", i, mem_we); else passed++;
    end
    total++; if (vblank !== 1'b1) $display("FAIL vblank_set: got %0b want 1", vblank); else passed++;
  endtask

  task automatic test_display_fetch();
    int exp_pix [5];
    exp_pix = '{8'h00, 8'hE3, 8'hE3, 8'h1C, 8'h1C};
    ram[0] = 8'hE3;
    ram[1] = 8'h1C;
    step(700, 0, 0, 0, 0, 0);
    for (int x = 0; x < 5; x++) begin
      step(x, 0, 0, 0, 0, 0);
      total++; if (pixel_out !== 8'(exp_pix[x])) $display("FAIL fetch_pixel x=%0d: got %0h want %0h", x, pixel_out, exp_pix[x]); else passed++;
      if (x == 0 || x == 2) begin
        total++; if (mem_addr !== 17'(x / 2)) $display("FAIL fetch_addr x=%0d: got %0d want %0d", x, mem_addr, x / 2); else passed++;
      end
      total++; if (mem_we !== 1'b0) $display("FAIL fetch_we x=%0d: got %0b want 0", x, mem_we); else passed++;
    end
  endtask

  task automatic test_row_scaling();
    step(4, 3, 0, 0, 0, 0);
    total++; if (mem_addr !== 17'd322) $display("FAIL row_addr: got %0d want 322", mem_addr); else passed++;
    step(5, 3, 0, 0, 0, 0);
    step(640, 3, 0, 0, 0, 0);
    total++; if (pixel_out !== 8'(m_pixel)) $display("FAIL row_hold: got %0h want %0h", pixel_out, m_pixel); else passed++;
    step(641, 3, 0, 0, 0, 0);
    total++; if (pixel_out !== 8'h00) $display("FAIL row_blank: got %0h want 0", pixel_out); else passed++;
  endtask

  task automatic test_blanking_drain();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 10 + i, 8'hA0 + i, 0);
      total++; if (cpu_full !== (i == 3)) $display("FAIL drain_full[%0d]: got %0b want %0b", i, cpu_full, i == 3); else passed++;
    end
    step(0, 0, 1, 14, 8'hA4, 0);
    total++; if (cpu_full !== 1'b1) $display("FAIL drain_full_hold: got %0b want 1", cpu_full); else passed++;
    for (int i = 0; i < 5; i++) begin
      step(800, 490, 0, 0, 0, 0);
      total++; if (mem_we !== (i < 4)) $display("FAIL drain_we[%0d]: got %0b want %0b", i, mem_we, i < 4); else passed++;
      if (i < 4) begin
        total++; if (mem_addr !== 17'(10 + i)) $display("FAIL drain_addr[%0d]: got %0d want %0d", i, mem_addr, 10 + i); else passed++;
        total++; if (mem_wdata !== 8'(8'hA0 + i)) $display("FAIL drain_data[%0d]: got %0h want %0h", i, mem_wdata, 8'hA0 + i); else passed++;
      end
    end
    total++; if (cpu_full !== 1'b0) $display("FAIL drain_empty: got %0b want 0", cpu_full); else passed++;
  endtask

  task automatic test_active_interleave();
    int ea [6];
    bit ew [6];
    ea = '{1650, 200, 1651, 201, 1652, 1652};
    ew = '{0, 1, 0, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(100 + i, 10, (i < 2), 200 + i, 8'h55 + i, 0);
      total++; if (mem_we !== ew[i]) $display("FAIL inter_we x=%0d: got %0b want %0b", 100 + i, mem_we, ew[i]); else passed++;
      total++; if (mem_addr !== 17'(ea[i])) $display("FAIL inter_addr x=%0d: got %0d want %0d", 100 + i, mem_addr, ea[i]); else passed++;
      total++; if (pixel_out !== 8'(m_pixel)) $display("FAIL inter_pixel x=%0d: got %0h want %0h", 100 + i, pixel_out, m_pixel); else passed++;
    end
  endtask

  task automatic test_out_of_range();
    step(700, 525, 1, 76800, 8'h77, 0);
    step(700, 525, 0, 0, 0, 0);
    total++; if (mem_we !== 1'b0) $display("FAIL oor_we: got %0b want 0", mem_we); else passed++;
    total++; if (cpu_drop !== 1'b1) $display("FAIL oor_drop: got %0b want 1", cpu_drop); else passed++;
    step(700, 525, 1, 76799, 8'h12, 0);
    step(700, 525, 0, 0, 0, 0);
    total++; if (mem_we !== 1'b1 || mem_addr !== 17'd76799) $display("FAIL oor_edge_ok: got we=%0b addr=%0d want we=1 addr=76799", mem_we, mem_addr); else passed++;
    for (int i = 0; i < 3; i++) step(i * 2, 0, 0, 0, 0, 0);
    total++; if (cpu_drop !== 1'b1) $display("FAIL oor_sticky: got %0b want 1", cpu_drop); else passed++;
    step(700, 525, 0, 0, 0, 1);
    total++; if (cpu_drop !== 1'b0) $display("FAIL oor_cleared: got %0b want 0", cpu_drop); else passed++;
  endtask

  task automatic test_random();
    int x, y, a;
    bit wr, rst;
    x = 600; y = 478;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        x = int'($urandom_range(0, 800));
        y = int'($urandom_range(0, 525));
      end else begin
        x = (x >= 800) ? 0 : x + 1;
        if (x == 0) y = (y >= 525) ? 0 : y + 1;
      end
      wr  = ($urandom_range(0, 2) == 0);
      a   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(76800, 131071))
                                         : int'($urandom_range(0, 76799));
      rst = ($urandom_range(0, 999) == 0);
      step(x, y, wr, a, int'($urandom_range(0, 255)), rst);
      total++; if (mem_we !== m_we) $display("FAIL rnd_we n=%0d: got %0b want %0b", n, mem_we, m_we); else passed++;
      total++; if (mem_addr !== 17'(m_addr)) $display("FAIL rnd_addr n=%0d: got %0d want %0d", n, mem_addr, m_addr); else passed++;
      total++; if (mem_wdata !== 8'(m_wdata)) $display("FAIL rnd_wdata n=%0d: got %0h want %0h", n, mem_wdata, m_wdata); else passed++;
      total++; if (pixel_out !== 8'(m_pixel)) $display("FAIL rnd_pixel n=%0d: got %0h want %0h", n, pixel_out, m_pixel); else passed++;
      total++; if (cpu_full !== m_full) $display("FAIL rnd_full n=%0d: got %0b want %0b", n, cpu_full, m_full); else passed++;
      total++; if (cpu_drop !== m_drop) $display("FAIL rnd_drop n=%0d: got %0b want %0b", n, cpu_drop, m_drop); else passed++;
      total++; if (vblank !== m_vblank) $display("FAIL rnd_vblank n=%0d: got %0b want %0b", n, vblank, m_vblank); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) ram[i] = 8'($urandom);
    test_reset();
    test_display_fetch();
    test_row_scaling();
    test_blanking_drain();
    test_active_interleave();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
